// File: rtl/control_unit.sv
// Multicycle Moore control FSM for the RISC-V datapath: decodes the IR and
// sequences every datapath control flag, one instruction at a time.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        LoadAOut,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        LoadMDR,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        DMemOp,
  output logic        IMemRead,
  output logic        halt,
  output logic [3:0]  state_out
);

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC_R     = 4'd3,
    S_EXEC_I     = 4'd4,
    S_MEM_ADDR   = 4'd5,
    S_MEM_RD     = 4'd6,
    S_LD_MDR     = 4'd7,
    S_LD_WB      = 4'd8,
    S_MEM_WR     = 4'd9,
    S_R_WB       = 4'd10,
    S_BRANCH     = 4'd11,
    S_BR_NT      = 4'd12,
    S_HALT       = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  state_t state, next_state;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_add, is_sub, is_and, is_addi, is_ld, is_sd, is_beq;
  logic       unused_fields;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  // Register and immediate fields only matter to the datapath.
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  assign is_add  = (opcode == OP_R) && (funct7 == 7'b0000000) && (funct3 == 3'b000);
  assign is_sub  = (opcode == OP_R) && (funct7 == 7'b0100000) && (funct3 == 3'b000);
  assign is_and  = (opcode == OP_R) && (funct7 == 7'b0000000) && (funct3 == 3'b111);
  assign is_addi = (opcode == OP_IMM) && (funct3 == 3'b000);
  assign is_ld   = (opcode == OP_LOAD) && (funct3 == 3'b011);
  assign is_sd   = (opcode == OP_STORE) && (funct3 == 3'b011);
  assign is_beq  = (opcode == OP_BRANCH) && (funct3 == 3'b000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    LoadAOut    = 1'b0;
    LoadRegA    = 1'b0;
    LoadRegB    = 1'b0;
    LoadMDR     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemToReg    = 1'b0;
    DMemOp      = 1'b0;
    IMemRead    = 1'b0;
    halt        = 1'b0;
    state_out   = 4'd0;

    case (state)
      S_FETCH:      next_state = S_FETCH_WAIT;
      S_FETCH_WAIT: next_state = S_DECODE;
      S_DECODE: begin
        if (is_add || is_sub || is_and) next_state = S_EXEC_R;
        else if (is_addi)               next_state = S_EXEC_I;
        else if (is_ld || is_sd)        next_state = S_MEM_ADDR;
        else if (is_beq)                next_state = S_BRANCH;
        else                            next_state = S_HALT;
      end
      S_EXEC_R, S_EXEC_I: next_state = S_R_WB;
      S_MEM_ADDR: next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   next_state = S_LD_MDR;
      S_LD_MDR:   next_state = S_LD_WB;
      S_LD_WB, S_MEM_WR, S_R_WB, S_BR_NT: next_state = S_FETCH;
      S_BRANCH:   next_state = alu_zero ? S_FETCH : S_BR_NT;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_HALT;
    endcase

    // Outputs are held at zero for as long as reset is asserted.
    if (reset) begin
      state_out = state;
      case (state)
        S_FETCH:      IMemRead = 1'b1;
        S_FETCH_WAIT: IRWrite  = 1'b1;
        S_DECODE: begin
          LoadRegA = 1'b1;
          LoadRegB = 1'b1;
          ALUSrcB  = 2'b11;
          ALUOp    = ALU_ADD;
          LoadAOut = 1'b1;
        end
        S_EXEC_R: begin
          ALUSrcA  = 1'b1;
          ALUOp    = is_sub ? ALU_SUB : (is_and ? ALU_AND : ALU_ADD);
          LoadAOut = 1'b1;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'b10;
          ALUOp    = ALU_ADD;
          LoadAOut = 1'b1;
        end
        S_LD_MDR: LoadMDR = 1'b1;
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALU_SUB;
          PCSource    = 1'b1;
          PCWriteCond = 1'b1;
        end
        S_HALT: halt = 1'b1;
        default: ;
      endcase

      // Every non-branch instruction retires through exactly one PC+4 state.
      if (state == S_R_WB || state == S_LD_WB || state == S_MEM_WR || state == S_BR_NT) begin
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        PCWrite = 1'b1;
      end
      if (state == S_R_WB || state == S_LD_WB) RegWrite = 1'b1;
      if (state == S_LD_WB)  MemToReg = 1'b1;
      if (state == S_MEM_WR) DMemOp   = 1'b1;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, reset/halt sequences and
// randomized instructions checked against a per-instruction-class model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic        alu_zero = 1'b0;
  logic        PCWrite, PCWriteCond, PCSource, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic        LoadAOut, LoadRegA, LoadRegB, LoadMDR, IRWrite;
  logic        RegWrite, MemToReg, DMemOp, IMemRead, halt;
  logic [3:0]  state_out;

  control_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .LoadAOut(LoadAOut), .LoadRegA(LoadRegA), .LoadRegB(LoadRegB),
    .LoadMDR(LoadMDR), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .DMemOp(DMemOp), .IMemRead(IMemRead),
    .halt(halt), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, pcsrc, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic       laout, lra, lrb, lmdr, irw, rw, m2r, dmem, imr, halt;
    logic [3:0] st;
  } outs_t;

  outs_t cur;
  assign cur = {PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp,
                LoadAOut, LoadRegA, LoadRegB, LoadMDR, IRWrite, RegWrite,
                MemToReg, DMemOp, IMemRead, halt, state_out};

  typedef enum {C_ADD, C_SUB, C_AND, C_ADDI, C_LD, C_SD, C_BEQ, C_ILL} cls_t;

  int    total = 0;
  int    bad = 0;
  outs_t rec [32];
  int    nrec;
  logic  timed_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic cls_t classify(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    if (op == 7'b0110011 && f7 == 7'h00 && f3 == 3'd0) return C_ADD;
    if (op == 7'b0110011 && f7 == 7'h20 && f3 == 3'd0) return C_SUB;
    if (op == 7'b0110011 && f7 == 7'h00 && f3 == 3'd7) return C_AND;
    if (op == 7'b0010011 && f3 == 3'd0) return C_ADDI;
    if (op == 7'b0000011 && f3 == 3'd3) return C_LD;
    if (op == 7'b0100011 && f3 == 3'd3) return C_SD;
    if (op == 7'b1100011 && f3 == 3'd0) return C_BEQ;
    return C_ILL;
  endfunction

  // Number of observed cycles, from FETCH up to (not including) the next FETCH.
  // An illegal instruction is observed for 3 cycles plus its first HALT cycle.
  function automatic int ref_len(input cls_t c, input logic z);
    case (c)
      C_LD:    return 7;
      C_BEQ:   return z ? 4 : 5;
      C_ILL:   return 4;
      default: return 5;
    endcase
  endfunction

  // Expected full output vector in cycle k of an instruction of class c.
  function automatic outs_t ref_cycle(input cls_t c, input int k);
    outs_t o;
    logic  pc4;
    o = '0;
    pc4 = 1'b0;
    if (k == 0) begin
      o.imr = 1'b1; o.st = 4'd0;
    end else if (k == 1) begin
      o.irw = 1'b1; o.st = 4'd1;
    end else if (k == 2) begin
      o.lra = 1'b1; o.lrb = 1'b1; o.srcb = 2'b11; o.aluop = 3'd1; o.laout = 1'b1; o.st = 4'd2;
    end else begin
      case (c)
        C_ILL: begin o.halt = 1'b1; o.st = 4'd15; end
        C_ADD, C_SUB, C_AND:
          if (k == 3) begin
            o.srca = 1'b1; o.laout = 1'b1; o.st = 4'd3;
            o.aluop = (c == C_SUB) ? 3'd2 : ((c == C_AND) ? 3'd3 : 3'd1);
          end else begin
            o.rw = 1'b1; pc4 = 1'b1; o.st = 4'd10;
          end
        C_ADDI:
          if (k == 3) begin
            o.srca = 1'b1; o.srcb = 2'b10; o.aluop = 3'd1; o.laout = 1'b1; o.st = 4'd4;
          end else begin
            o.rw = 1'b1; pc4 = 1'b1; o.st = 4'd10;
          end
        C_LD:
          if (k == 3) begin
            o.srca = 1'b1; o.srcb = 2'b10; o.aluop = 3'd1; o.laout = 1'b1; o.st = 4'd5;
          end else if (k == 4) o.st = 4'd6;
          else if (k == 5) begin
            o.lmdr = 1'b1; o.st = 4'd7;
          end else begin
            o.rw = 1'b1; o.m2r = 1'b1; pc4 = 1'b1; o.st = 4'd8;
          end
        C_SD:
          if (k == 3) begin
            o.srca = 1'b1; o.srcb = 2'b10; o.aluop = 3'd1; o.laout = 1'b1; o.st = 4'd5;
          end else begin
            o.dmem = 1'b1; pc4 = 1'b1; o.st = 4'd9;
          end
        C_BEQ:
          if (k == 3) begin
            o.srca = 1'b1; o.aluop = 3'd2; o.pcsrc = 1'b1; o.pcwc = 1'b1; o.st = 4'd11;
          end else begin
            pc4 = 1'b1; o.st = 4'd12;
          end
        default: ;
      endcase
      if (pc4) begin
        o.srcb = 2'b01; o.aluop = 3'd1; o.pcw = 1'b1;
      end
    end
    return o;
  endfunction

  // Starts in FETCH at a falling edge; records outputs each cycle until the
  // FSM returns to FETCH or enters HALT. alu_zero is noise except in BRANCH.
  task automatic run_instr(input logic [31:0] ins, input logic z);
    instruction = ins;
    nrec = 0;
    timed_out = 1'b1;
    for (int n = 0; n < 24; n++) begin
      rec[nrec] = cur;
      nrec++;
      alu_zero = (cur.st == 4'd11) ? z : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cur.st == 4'd0) begin
        timed_out = 1'b0;
        break;
      end
      if (cur.st == 4'd15) begin
        rec[nrec] = cur;
        nrec++;
        timed_out = 1'b0;
        break;
      end
    end
    chk("instr timeout", 32'(timed_out), 32'd0);
  endtask

  task automatic compare_model(input string name, input logic [31:0] ins, input logic z);
    cls_t c;
    int   len;
    c = classify(ins);
    len = ref_len(c, z);
    chk($sformatf("%s len", name), 32'(nrec), 32'(len));
    for (int k = 0; k < nrec && k < len; k++)
      chk($sformatf("%s cyc%0d", name, k), 32'(rec[k]), 32'(ref_cycle(c, k)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("reset outs async", 32'(cur), 32'd0);
    @(posedge clk);
    #1 chk("reset outs held", 32'(cur), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("reset release fetch", 32'(cur), 32'(ref_cycle(C_ADD, 0)));
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          len;
    logic [31:0] seq;
    logic [2:0]  exec_op;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] rins;
  logic [4:0]  ra, rb, rd;
  logic [6:0]  rf7;
  logic        rz;
  int          sel;

  initial begin
    // state sequence is packed most-significant nibble first
    tbl[0] = '{32'h002081B3, 1'b0, 5, 32'h0123A000, 3'd1};
    tbl[1] = '{32'h402081B3, 1'b0, 5, 32'h0123A000, 3'd2};
    tbl[2] = '{32'h0020F1B3, 1'b1, 5, 32'h0123A000, 3'd3};
    tbl[3] = '{32'h00108093, 1'b0, 5, 32'h0124A000, 3'd1};
    tbl[4] = '{32'h0080B283, 1'b0, 7, 32'h01256780, 3'd1};
    tbl[5] = '{32'h0050B423, 1'b1, 5, 32'h01259000, 3'd1};
    tbl[6] = '{32'h00208463, 1'b1, 4, 32'h012B0000, 3'd2};
    tbl[7] = '{32'h00208463, 1'b0, 5, 32'h012BC000, 3'd2};

    #12 chk("reset state", 32'(cur), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("first fetch", 32'(cur), 32'(ref_cycle(C_ADD, 0)));

    for (int i = 0; i < 8; i++) begin
      run_instr(tbl[i].ins, tbl[i].z);
      chk($sformatf("vec%0d len", i), 32'(nrec), 32'(tbl[i].len));
      for (int k = 0; k < nrec && k < tbl[i].len; k++)
        chk($sformatf("vec%0d state%0d", i, k), 32'(rec[k].st), 32'(tbl[i].seq[31-4*k -: 4]));
      if (nrec > 3) chk($sformatf("vec%0d exec aluop", i), 32'(rec[3].aluop), 32'(tbl[i].exec_op));
      compare_model($sformatf("vec%0d", i), tbl[i].ins, tbl[i].z);
    end

    // illegal instruction parks in HALT until reset
    run_instr(32'hFFFFFFFF, 1'b0);
    compare_model("illegal", 32'hFFFFFFFF, 1'b0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk($sformatf("halt hold %0d", n), 32'(cur), 32'(ref_cycle(C_ILL, 3)));
    end
    do_reset();

    // reset during LD_MDR aborts the load
    instruction = 32'h0080B283;
    for (int n = 0; n < 12 && cur.st != 4'd7; n++) @(negedge clk);
    chk("reach LD_MDR", 32'(cur.st), 32'd7);
    #2 reset = 1'b0;
    #1 chk("mid reset outs", 32'(cur), 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1 chk($sformatf("mid reset held %0d", n), 32'(cur), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1 chk("after mid reset", 32'(cur), 32'(ref_cycle(C_LD, 0)));
    @(negedge clk);
    chk("after mid reset next", 32'(cur), 32'(ref_cycle(C_LD, 1)));
    do_reset();

    // randomized instruction mix
    for (int it = 0; it < 80; it++) begin
      sel = int'($urandom_range(0, 9));
      ra  = 5'($urandom);
      rb  = 5'($urandom);
      rd  = 5'($urandom);
      rf7 = 7'($urandom);
      rz  = 1'($urandom_range(0, 1));
      case (sel)
        0:       rins = $urandom;
        1:       rins = {7'h00, rb, ra, 3'd0, rd, 7'b0110011};
        2:       rins = {7'h20, rb, ra, 3'd0, rd, 7'b0110011};
        3:       rins = {7'h00, rb, ra, 3'd7, rd, 7'b0110011};
        4:       rins = {rf7, rb, ra, 3'd0, rd, 7'b0010011};
        5:       rins = {rf7, rb, ra, 3'd3, rd, 7'b0000011};
        6:       rins = {rf7, rb, ra, 3'd3, rd, 7'b0100011};
        7, 8:    rins = {rf7, rb, ra, 3'd0, rd, 7'b1100011};
        default: rins = {rf7, rb, ra, 3'($urandom_range(0, 7)), rd, 7'b0110011};
      endcase
      run_instr(rins, rz);
      compare_model($sformatf("rnd%0d %08h", it, rins), rins, rz);
      if (classify(rins) == C_ILL) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
